// File: rtl/time_cycle_generator.sv
// Initiator for the CStart/CEnd timed-cycle protocol: issues bursts of cycles with a
// programmable gap, plus optional one-shot malformed-cycle injection for checker testing.
module time_cycle_generator #(
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Go,
    input  logic [CNT_W-1:0] NumCycles,
    input  logic [GAP_W-1:0] Gap,
    input  logic [1:0]       ErrMode,
    input  logic             Abort,
    output logic             CStart,
    output logic             CEnd,
    output logic             Busy,
    output logic             Done,
    output logic [CNT_W-1:0] CyclesSent
);

    typedef enum logic [2:0] {
        S_Idle,
        S_Start,
        S_Mid,
        S_End,
        S_Post,
        S_Gap,
        S_Done
    } state_t;

    localparam logic [1:0] EM_NORMAL = 2'b00;
    localparam logic [1:0] EM_EARLY  = 2'b01;
    localparam logic [1:0] EM_LATE   = 2'b10;
    localparam logic [1:0] EM_DOUBLE = 2'b11;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] num_q;
    logic [GAP_W-1:0] gap_q;
    logic [GAP_W-1:0] gap_cnt;
    logic [1:0]       err_q;
    logic             abort_q;
    logic [CNT_W-1:0] sent;

    // A pulse on Abort in the same clock as the decision still counts as "seen".
    logic abort_seen;
    assign abort_seen = abort_q | Abort;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state   <= S_Idle;
            num_q   <= '0;
            gap_q   <= '0;
            gap_cnt <= '0;
            err_q   <= '0;
            abort_q <= 1'b0;
            sent    <= '0;
        end else begin
            state <= state_nxt;

            if (state == S_Idle) abort_q <= 1'b0;
            else if (Abort)      abort_q <= 1'b1;

            case (state)
                S_Idle: begin
                    if (Go) begin
                        num_q <= NumCycles;
                        gap_q <= Gap;
                        err_q <= ErrMode;
                        sent  <= '0;
                    end
                end
                S_Start: sent <= sent + CNT_W'(1);
                S_Post:  if (state_nxt == S_Gap) gap_cnt <= gap_q;
                S_Gap:   gap_cnt <= gap_cnt - GAP_W'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_Idle: begin
                if (Go) state_nxt = (NumCycles == '0) ? S_Done : S_Start;
            end
            S_Start: state_nxt = S_Mid;
            S_Mid:   state_nxt = S_End;
            S_End:   state_nxt = S_Post;
            S_Post: begin
                if (err_q != EM_NORMAL || abort_seen || sent == num_q) state_nxt = S_Done;
                else if (gap_q == '0)                                  state_nxt = S_Start;
                else                                                   state_nxt = S_Gap;
            end
            S_Gap: begin
                if (abort_seen)        state_nxt = S_Done;
                else if (gap_cnt == 1) state_nxt = S_Start;
            end
            S_Done:  state_nxt = S_Idle;
            default: state_nxt = S_Idle;
        endcase
    end

    // Outputs are a pure decode of state so a reset drops them without waiting for a clock.
    always_comb begin
        CStart = (state == S_Start);
        Busy   = (state != S_Idle);
        Done   = (state == S_Done);
        CEnd   = 1'b0;
        case (state)
            S_Mid:   CEnd = (err_q == EM_EARLY);
            S_End:   CEnd = (err_q == EM_NORMAL) || (err_q == EM_DOUBLE);
            S_Post:  CEnd = (err_q == EM_LATE)   || (err_q == EM_DOUBLE);
            default: CEnd = 1'b0;
        endcase
    end

    assign CyclesSent = sent;

endmodule

// File: tb/tb_time_cycle_generator.sv
// Directed bench for time_cycle_generator: per-clock checks of CStart/CEnd/Busy/Done
// against hand-derived clock masks (bit i = clock i after the Go edge).
module tb_time_cycle_generator;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       Go;
    logic [7:0] NumCycles;
    logic [3:0] Gap;
    logic [1:0] ErrMode;
    logic       Abort;
    logic       CStart, CEnd, Busy, Done;
    logic [7:0] CyclesSent;

    int n_asserts = 0;
    int n_fails   = 0;

    always #5 Clk = ~Clk;

    time_cycle_generator #(.CNT_W(8), .GAP_W(4)) dut (
        .Clk(Clk), .Rst(Rst), .Go(Go), .NumCycles(NumCycles), .Gap(Gap),
        .ErrMode(ErrMode), .Abort(Abort), .CStart(CStart), .CEnd(CEnd),
        .Busy(Busy), .Done(Done), .CyclesSent(CyclesSent)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive Go for one edge; returns 1 ns into clock 1.
    task automatic launch(input logic [7:0] n, input logic [3:0] g, input logic [1:0] em,
                          input logic abt);
        @(negedge Clk);
        Go = 1'b1; NumCycles = n; Gap = g; ErrMode = em; Abort = abt;
        @(posedge Clk); #1;
        Go = 1'b0; Abort = 1'b0;
    endtask

    // Check clocks first..last; Busy is expected high through done_clk.
    task automatic expect_clks(input string tag, input int first, input int last,
                               input logic [31:0] cs_m, input logic [31:0] ce_m,
                               input int done_clk, input int abort_clk);
        for (int i = first; i <= last; i++) begin
            if (i > first) begin
                @(posedge Clk); #1;
            end
            chk($sformatf("%s.cstart@%0d", tag, i), 32'(CStart), 32'(cs_m[i]));
            chk($sformatf("%s.cend@%0d",   tag, i), 32'(CEnd),   32'(ce_m[i]));
            chk($sformatf("%s.done@%0d",   tag, i), 32'(Done),   32'(i == done_clk));
            chk($sformatf("%s.busy@%0d",   tag, i), 32'(Busy),   32'(i <= done_clk));
            Abort = (i == abort_clk);
        end
        Abort = 1'b0;
    endtask

    initial begin
        Rst = 1'b0; Go = 1'b0; NumCycles = '0; Gap = '0; ErrMode = '0; Abort = 1'b0;
        #12;
        chk("reset.cstart", 32'(CStart), 0);
        chk("reset.cend",   32'(CEnd),   0);
        chk("reset.busy",   32'(Busy),   0);
        chk("reset.done",   32'(Done),   0);
        chk("reset.sent",   32'(CyclesSent), 0);
        @(negedge Clk); Rst = 1'b1;

        // Three back-to-back cycles, no gap.
        launch(8'd3, 4'd0, 2'b00, 1'b0);
        expect_clks("n3g0", 1, 15, 32'h0000_0222, 32'h0000_0888, 13, 0);
        chk("n3g0.sent", 32'(CyclesSent), 3);

        // Two cycles with 5 idle clocks between.
        launch(8'd2, 4'd5, 2'b00, 1'b0);
        expect_clks("n2g5", 1, 16, 32'h0000_0402, 32'h0000_1008, 14, 0);
        chk("n2g5.sent", 32'(CyclesSent), 2);

        // Malformed cycles: single cycle regardless of NumCycles.
        launch(8'd4, 4'd0, 2'b01, 1'b0);
        expect_clks("early", 1, 7, 32'h02, 32'h04, 5, 0);
        chk("early.sent", 32'(CyclesSent), 1);
        launch(8'd4, 4'd0, 2'b10, 1'b0);
        expect_clks("late", 1, 7, 32'h02, 32'h10, 5, 0);
        chk("late.sent", 32'(CyclesSent), 1);
        launch(8'd4, 4'd0, 2'b11, 1'b0);
        expect_clks("double", 1, 7, 32'h02, 32'h18, 5, 0);
        chk("double.sent", 32'(CyclesSent), 1);

        // Empty burst: Done right away; Go held through S_Done must be ignored.
        @(negedge Clk);
        Go = 1'b1; NumCycles = 8'd0; Gap = '0; ErrMode = '0;
        @(posedge Clk); #1;
        expect_clks("n0", 1, 1, 32'h0, 32'h0, 1, 0);
        @(posedge Clk); #1;
        Go = 1'b0;
        expect_clks("n0", 2, 3, 32'h0, 32'h0, 1, 0);
        chk("n0.sent", 32'(CyclesSent), 0);

        // Abort during 2nd cycle's S_Mid (clock 6) lets that cycle finish.
        launch(8'd10, 4'd0, 2'b00, 1'b0);
        expect_clks("abort_mid", 1, 11, 32'h22, 32'h88, 9, 6);
        chk("abort_mid.sent", 32'(CyclesSent), 2);

        // Abort in S_Gap (clock 5) ends the burst the next clock.
        launch(8'd3, 4'd3, 2'b00, 1'b0);
        expect_clks("abort_gap", 1, 8, 32'h02, 32'h08, 6, 5);
        chk("abort_gap.sent", 32'(CyclesSent), 1);

        // Go and Abort together in S_Idle: Go wins and the full burst runs.
        launch(8'd2, 4'd0, 2'b00, 1'b1);
        expect_clks("go_abort", 1, 10, 32'h22, 32'h88, 9, 0);
        chk("go_abort.sent", 32'(CyclesSent), 2);

        // Reset asserted during S_End drops outputs at once.
        launch(8'd3, 4'd0, 2'b00, 1'b0);
        expect_clks("rst_pre", 1, 3, 32'h02, 32'h08, 99, 0);
        #2 Rst = 1'b0;
        #1;
        chk("rst_mid.cend", 32'(CEnd), 0);
        chk("rst_mid.busy", 32'(Busy), 0);
        chk("rst_mid.done", 32'(Done), 0);
        chk("rst_mid.sent", 32'(CyclesSent), 0);
        @(posedge Clk); #1;
        chk("rst_hold.busy", 32'(Busy), 0);
        @(negedge Clk); Rst = 1'b1;
        launch(8'd1, 4'd0, 2'b00, 1'b0);
        expect_clks("post_rst", 1, 6, 32'h02, 32'h08, 5, 0);
        chk("post_rst.sent", 32'(CyclesSent), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
